// File: rtl/fpu_issue_seq_if.sv
// Issue-request and writeback handshake bundle for the FP issue sequencer.
// The master side is decode/issue plus writeback; the slave side is the sequencer.
interface fpu_issue_seq_if;
    // issue request channel
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_ctrl;
    logic [31:0] req_ds_val;
    logic [31:0] req_dt_val;
    logic [5:0]  req_dd;
    logic [15:0] req_imm;

    // writeback channel
    logic        wb_valid;
    logic        wb_ready;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;

    modport master (
        output req_valid, req_ctrl, req_ds_val, req_dt_val, req_dd, req_imm, wb_ready,
        input  req_ready, wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  req_valid, req_ctrl, req_ds_val, req_dt_val, req_dd, req_imm, wb_ready,
        output req_ready, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/fpu_issue_seq.sv
// Multi-cycle sequencer around the combinational FP datapath.
// Accepts one op, holds its operands on the fpu_* registers for a per-op
// latency, captures the result and presents it to writeback. One op in flight.
module fpu_issue_seq #(
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MUL  = 1,
    parameter int unsigned LAT_DIV  = 3,
    parameter int unsigned LAT_SQRT = 3,
    parameter int unsigned LAT_MISC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    fpu_issue_seq_if.slave bus,
    output logic [3:0]  fpu_ctrl,
    output logic [31:0] fpu_ds_val,
    output logic [31:0] fpu_dt_val,
    output logic [5:0]  fpu_dd,
    output logic [15:0] fpu_imm,
    input  logic [31:0] fpu_dd_val,
    input  logic [5:0]  fpu_reg_addr,
    output logic        busy,
    output logic [5:0]  busy_addr,
    output logic        err_illegal
);

    // Latencies must fit the 3-bit down-counter and be at least one cycle.
    if (LAT_ADD  < 1 || LAT_ADD  > 7 ||
        LAT_MUL  < 1 || LAT_MUL  > 7 ||
        LAT_DIV  < 1 || LAT_DIV  > 7 ||
        LAT_SQRT < 1 || LAT_SQRT > 7 ||
        LAT_MISC < 1 || LAT_MISC > 7) begin : g_lat_range_error
        $error("fpu_issue_seq: every LAT_* parameter must lie in 1..7");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        wb_valid_q;
    logic [5:0]  wb_addr_q;
    logic [31:0] wb_data_q;

    logic        accept;
    logic        ctrl_illegal;
    logic [2:0]  lat_sel;

    // Ready only when idle or when the pending result leaves this very edge.
    assign bus.req_ready = !flush && ((state == ST_IDLE) || ((state == ST_DONE) && bus.wb_ready));
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;

    assign busy      = (state != ST_IDLE);
    assign busy_addr = busy ? fpu_dd : '0;

    // Decode the requested op into its execution latency; codes 0 and 15 are illegal.
    always_comb begin
        lat_sel      = '0;
        ctrl_illegal = 1'b0;
        case (bus.req_ctrl)
            4'd1, 4'd2:   lat_sel = 3'(LAT_ADD);
            4'd3:         lat_sel = 3'(LAT_MUL);
            4'd4:         lat_sel = 3'(LAT_DIV);
            4'd5:         lat_sel = 3'(LAT_SQRT);
            4'd0, 4'd15:  ctrl_illegal = 1'b1;
            default:      lat_sel = 3'(LAT_MISC);
        endcase
    end

    // Sequencer FSM with registered operand, result and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            fpu_ctrl    <= '0;
            fpu_ds_val  <= '0;
            fpu_dt_val  <= '0;
            fpu_dd      <= '0;
            fpu_imm     <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            err_illegal <= 1'b0;
        end else if (flush) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wb_valid_q  <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= 1'b0;

            case (state)
                ST_EXEC: begin
                    if (cnt <= 3'd1) begin
                        wb_data_q  <= fpu_dd_val;
                        wb_addr_q  <= fpu_reg_addr;
                        wb_valid_q <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_IDLE: ;
                default: state <= ST_IDLE;
            endcase

            // An accept can only happen from IDLE or from a completing DONE, both of
            // which already target IDLE above; a legal op overrides that with EXEC.
            if (accept) begin
                fpu_ctrl   <= bus.req_ctrl;
                fpu_ds_val <= bus.req_ds_val;
                fpu_dt_val <= bus.req_dt_val;
                fpu_dd     <= bus.req_dd;
                fpu_imm    <= bus.req_imm;
                if (ctrl_illegal) begin
                    err_illegal <= 1'b1;
                    cnt         <= '0;
                end else begin
                    cnt   <= lat_sel;
                    state <= ST_EXEC;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq: a table of single-op vectors plus
// hand-written sequences for back-to-back, flush, illegal-in-DONE and reset.
module tb_fpu_issue_seq;

    localparam int unsigned LAT_ADD  = 2;
    localparam int unsigned LAT_MUL  = 1;
    localparam int unsigned LAT_DIV  = 3;
    localparam int unsigned LAT_SQRT = 5;
    localparam int unsigned LAT_MISC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  fpu_ctrl;
    logic [31:0] fpu_ds_val;
    logic [31:0] fpu_dt_val;
    logic [5:0]  fpu_dd;
    logic [15:0] fpu_imm;
    logic [31:0] fpu_dd_val;
    logic [5:0]  fpu_reg_addr;
    logic        busy;
    logic [5:0]  busy_addr;
    logic        err_illegal;

    fpu_issue_seq_if bus();

    fpu_issue_seq #(
        .LAT_ADD (LAT_ADD),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV),
        .LAT_SQRT(LAT_SQRT),
        .LAT_MISC(LAT_MISC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .fpu_ctrl    (fpu_ctrl),
        .fpu_ds_val  (fpu_ds_val),
        .fpu_dt_val  (fpu_dt_val),
        .fpu_dd      (fpu_dd),
        .fpu_imm     (fpu_imm),
        .fpu_dd_val  (fpu_dd_val),
        .fpu_reg_addr(fpu_reg_addr),
        .busy        (busy),
        .busy_addr   (busy_addr),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational FP datapath: known answers for the test operands.
    function automatic logic [31:0] fake_fpu(input logic [3:0] c, input logic [31:0] s,
                                             input logic [31:0] t, input logic [15:0] im);
        logic [6:0] idx;
        idx = im[6:0];
        if (c == 4'd1 && s == 32'h3F80_0000 && t == 32'h4000_0000) return 32'h4040_0000;
        if (c == 4'd2 && s == 32'h4040_0000 && t == 32'h3F80_0000) return 32'h4000_0000;
        if (c == 4'd3 && s == 32'h3FC0_0000 && t == 32'h4000_0000) return 32'h4040_0000;
        if (c == 4'd4 && s == 32'h40C0_0000 && t == 32'h4000_0000) return 32'h4040_0000;
        if (c == 4'd5 && s == 32'h4110_0000) return 32'h4040_0000;
        if (c == 4'd14) return (idx == 7'd3) ? 32'h4000_0000 : 32'h3F80_0000;
        return s ^ t;
    endfunction

    assign fpu_dd_val   = fake_fpu(fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_imm);
    assign fpu_reg_addr = fpu_dd;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] ds;
        logic [31:0] dt;
        logic [5:0]  dd;
        logic [15:0] imm;
        int unsigned hold;
        int unsigned lat;
        logic [31:0] data;
        logic        bad;
    } vec_t;

    vec_t vecs[9];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] c, input logic [31:0] s, input logic [31:0] t,
                             input logic [5:0] d, input logic [15:0] im);
        bus.req_ctrl   = c;
        bus.req_ds_val = s;
        bus.req_dt_val = t;
        bus.req_dd     = d;
        bus.req_imm    = im;
        bus.req_valid  = 1'b1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] s, input logic [31:0] t,
                         input logic [5:0] d, input logic [15:0] im);
        drive_req(c, s, t, d, im);
        step();
        bus.req_valid = 1'b0;
    endtask

    // Count edges until wb_valid rises, giving up after 16.
    task automatic wait_wb(output int unsigned n);
        n = 0;
        while (!bus.wb_valid && n < 16) begin
            step();
            n++;
        end
    endtask

    // Observe wb_valid for a number of cycles and report whether it ever rose.
    task automatic watch_wb(input int unsigned cycles, output logic seen);
        seen = 1'b0;
        for (int unsigned k = 0; k < cycles; k++) begin
            if (bus.wb_valid) seen = 1'b1;
            step();
        end
        if (bus.wb_valid) seen = 1'b1;
    endtask

    initial begin
        int unsigned n;
        logic        seen;
        logic        hold_ok;

        //            ctrl   ds            dt            dd     imm     hold lat       data          bad
        vecs[0] = '{4'd1,  32'h3F80_0000, 32'h4000_0000, 6'd5,  16'h0,  0, LAT_ADD,  32'h4040_0000, 1'b0};
        vecs[1] = '{4'd3,  32'h3FC0_0000, 32'h4000_0000, 6'd7,  16'h0,  5, LAT_MUL,  32'h4040_0000, 1'b0};
        vecs[2] = '{4'd2,  32'h4040_0000, 32'h3F80_0000, 6'd12, 16'h0,  1, LAT_ADD,  32'h4000_0000, 1'b0};
        vecs[3] = '{4'd4,  32'h40C0_0000, 32'h4000_0000, 6'd33, 16'h0,  0, LAT_DIV,  32'h4040_0000, 1'b0};
        vecs[4] = '{4'd5,  32'h4110_0000, 32'h0,         6'd63, 16'h0,  2, LAT_SQRT, 32'h4040_0000, 1'b0};
        vecs[5] = '{4'd14, 32'h0,         32'h0,         6'd9,  16'h3,  0, LAT_MISC, 32'h4000_0000, 1'b0};
        vecs[6] = '{4'd6,  32'h0000_1234, 32'h0000_00FF, 6'd1,  16'h0,  0, LAT_MISC, 32'h0000_12CB, 1'b0};
        vecs[7] = '{4'd0,  32'h1111_1111, 32'h2222_2222, 6'd20, 16'h0,  0, 0,        32'h0,         1'b1};
        vecs[8] = '{4'd15, 32'h3333_3333, 32'h4444_4444, 6'd21, 16'h0,  0, 0,        32'h0,         1'b1};

        rst            = 1'b1;
        flush          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_ctrl   = '0;
        bus.req_ds_val = '0;
        bus.req_dt_val = '0;
        bus.req_dd     = '0;
        bus.req_imm    = '0;
        bus.wb_ready   = 1'b0;
        step();
        step();

        check("rst_wb_valid", 32'(bus.wb_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fpu_ctrl", 32'(fpu_ctrl), 0);
        check("rst_err", 32'(err_illegal), 0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(bus.req_ready), 1);

        // ---------------- table-driven single ops ----------------
        for (int i = 0; i < 9; i++) begin
            bus.wb_ready = 1'b0;
            check("ready_idle", 32'(bus.req_ready), 1);
            issue(vecs[i].ctrl, vecs[i].ds, vecs[i].dt, vecs[i].dd, vecs[i].imm);
            check("fpu_ctrl_reg", 32'(fpu_ctrl), 32'(vecs[i].ctrl));
            check("fpu_ds_reg", fpu_ds_val, vecs[i].ds);
            if (vecs[i].bad) begin
                check("err_pulse", 32'(err_illegal), 1);
                check("illegal_busy", 32'(busy), 0);
                check("illegal_ready", 32'(bus.req_ready), 1);
                step();
                check("err_clear", 32'(err_illegal), 0);
                watch_wb(4, seen);
                check("illegal_no_wb", 32'(seen), 0);
            end else begin
                check("busy_exec", 32'(busy), 1);
                check("busy_addr_exec", 32'(busy_addr), 32'(vecs[i].dd));
                wait_wb(n);
                check("latency", n, vecs[i].lat);
                check("wb_data", bus.wb_data, vecs[i].data);
                check("wb_addr", 32'(bus.wb_addr), 32'(vecs[i].dd));
                hold_ok = 1'b1;
                for (int unsigned h = 0; h < vecs[i].hold; h++) begin
                    step();
                    if (!bus.wb_valid || bus.wb_data !== vecs[i].data || bus.req_ready)
                        hold_ok = 1'b0;
                end
                check("hold_stable", 32'(hold_ok), 1);
                bus.wb_ready = 1'b1;
                #1;
                check("ready_on_hs", 32'(bus.req_ready), 1);
                step();
                bus.wb_ready = 1'b0;
                check("wb_drop", 32'(bus.wb_valid), 0);
                check("idle_busy", 32'(busy), 0);
                check("idle_busy_addr", 32'(busy_addr), 0);
            end
        end

        // ---------------- back-to-back: fmul done, fsub accepted same edge ----------------
        issue(4'd3, 32'h3FC0_0000, 32'h4000_0000, 6'd3, 16'h0);
        wait_wb(n);
        check("b2b_mul_lat", n, LAT_MUL);
        drive_req(4'd2, 32'h4040_0000, 32'h3F80_0000, 6'd4, 16'h0);
        bus.wb_ready = 1'b1;
        #1;
        check("b2b_ready", 32'(bus.req_ready), 1);
        step();
        bus.req_valid = 1'b0;
        bus.wb_ready  = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_wb_low", 32'(bus.wb_valid), 0);
        check("b2b_busy_addr", 32'(busy_addr), 4);
        wait_wb(n);
        check("b2b_sub_lat", n, LAT_ADD);
        check("b2b_sub_data", bus.wb_data, 32'h4000_0000);
        check("b2b_sub_addr", 32'(bus.wb_addr), 4);
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
        check("b2b_idle", 32'(busy), 0);

        // ---------------- flush one cycle into fdiv ----------------
        issue(4'd4, 32'h40C0_0000, 32'h4000_0000, 6'd10, 16'h0);
        flush = 1'b1;
        drive_req(4'd1, 32'h3F80_0000, 32'h4000_0000, 6'd11, 16'h0);
        #1;
        check("flush_ready_low", 32'(bus.req_ready), 0);
        step();
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        check("flush_busy", 32'(busy), 0);
        check("flush_no_accept", 32'(fpu_dd), 10);
        #1;
        check("flush_ready_after", 32'(bus.req_ready), 1);
        watch_wb(6, seen);
        check("flush_no_wb", 32'(seen), 0);

        // ---------------- flush beats the writeback handshake in DONE ----------------
        issue(4'd3, 32'h3FC0_0000, 32'h4000_0000, 6'd13, 16'h0);
        wait_wb(n);
        check("fdone_lat", n, LAT_MUL);
        flush        = 1'b1;
        bus.wb_ready = 1'b1;
        drive_req(4'd1, 32'h3F80_0000, 32'h4000_0000, 6'd14, 16'h0);
        #1;
        check("fdone_ready_low", 32'(bus.req_ready), 0);
        step();
        flush         = 1'b0;
        bus.wb_ready  = 1'b0;
        bus.req_valid = 1'b0;
        check("fdone_wb_low", 32'(bus.wb_valid), 0);
        check("fdone_busy", 32'(busy), 0);
        check("fdone_no_accept", 32'(fpu_dd), 13);

        // ---------------- illegal op accepted while a result completes ----------------
        issue(4'd3, 32'h3FC0_0000, 32'h4000_0000, 6'd15, 16'h0);
        wait_wb(n);
        check("idone_lat", n, LAT_MUL);
        drive_req(4'd15, 32'h0, 32'h0, 6'd16, 16'h0);
        bus.wb_ready = 1'b1;
        #1;
        check("idone_ready", 32'(bus.req_ready), 1);
        step();
        bus.req_valid = 1'b0;
        bus.wb_ready  = 1'b0;
        check("idone_err", 32'(err_illegal), 1);
        check("idone_busy", 32'(busy), 0);
        check("idone_wb_low", 32'(bus.wb_valid), 0);
        step();
        check("idone_err_clear", 32'(err_illegal), 0);

        // ---------------- reset in the middle of fsqrt ----------------
        issue(4'd5, 32'h4110_0000, 32'h0, 6'd22, 16'h5);
        step();
        check("rexec_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rexec_fpu_ctrl", 32'(fpu_ctrl), 0);
        check("rexec_fpu_ds", fpu_ds_val, 0);
        check("rexec_fpu_dd", 32'(fpu_dd), 0);
        check("rexec_fpu_imm", 32'(fpu_imm), 0);
        check("rexec_wb_data", bus.wb_data, 0);
        check("rexec_wb_addr", 32'(bus.wb_addr), 0);
        check("rexec_busy_clear", 32'(busy), 0);
        check("rexec_busy_addr", 32'(busy_addr), 0);
        watch_wb(8, seen);
        check("rexec_no_wb", 32'(seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
